// File: rtl/riscv_pkg.sv
// Shared encodings for the reduced RISC-V control path:
// opcodes, ALU/immediate selector codes, FSM state type and NOP word.
package riscv_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_ADD = 7'b0000000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: maps the latched instruction word to
// datapath control and classification flags. Anything outside addi/add/bne
// is reported illegal with safe (no-write, non-branch) controls.
module ctrl_decode
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic        alusrc,
  output logic [2:0]  aluctrl,
  output logic [1:0]  immsrc,
  output logic        wr_en,
  output logic        is_branch,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  // register fields are consumed by the top, not by the decoder
  assign unused_fields = ^instr[24:15] ^ ^instr[11:7];

  // Decode table; defaults describe an illegal instruction
  always_comb begin
    alusrc    = 1'b0;
    aluctrl   = ALU_ADD;
    immsrc    = IMM_I;
    wr_en     = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b1;
    case (opcode)
      OPC_OP_IMM: begin
        if (funct3 == F3_ADD) begin
          alusrc  = 1'b1;
          wr_en   = 1'b1;
          illegal = 1'b0;
        end
      end
      OPC_OP: begin
        if (funct3 == F3_ADD && funct7 == F7_ADD) begin
          wr_en   = 1'b1;
          illegal = 1'b0;
        end
      end
      OPC_BRANCH: begin
        if (funct3 == F3_BNE) begin
          aluctrl   = ALU_SUB;
          immsrc    = IMM_B;
          is_branch = 1'b1;
          illegal   = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the addi/add/bne datapath.
// Owns PC, latched instruction and retired-instruction counter; a fault
// (illegal encoding or misaligned branch target) parks the FSM in HALT.
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int             WAD      = 5,
  parameter int             WD       = 32,
  parameter logic [WD-1:0]  RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           imem_req,
  output logic [WD-1:0]  imem_addr,
  input  logic           imem_ack,
  input  logic [WD-1:0]  imem_rdata,
  input  logic           EQ,
  input  logic [WD-1:0]  IMM,
  output logic [WD-1:0]  instr,
  output logic [WAD-1:0] AdIn,
  output logic [WAD-1:0] AdOut1,
  output logic [WAD-1:0] AdOut2,
  output logic           ALUsrc,
  output logic [2:0]     ALUctrl,
  output logic           RegWrite,
  output logic [1:0]     IMMsrc,
  output logic [WD-1:0]  pc,
  output logic           halt,
  output logic [WD-1:0]  instret
);

  state_t        state_reg, state_next;
  logic          run_reg;
  logic [WD-1:0] pc_reg, pc_next;
  logic [WD-1:0] instr_reg;
  logic [WD-1:0] instret_reg, instret_next;
  logic [WD-1:0] target;
  logic          fetch_fire;
  logic          wr_en, is_branch, illegal;

  ctrl_decode u_decode (
    .instr     (instr_reg[31:0]),
    .alusrc    (ALUsrc),
    .aluctrl   (ALUctrl),
    .immsrc    (IMMsrc),
    .wr_en     (wr_en),
    .is_branch (is_branch),
    .illegal   (illegal)
  );

  assign instr      = instr_reg;
  assign pc         = pc_reg;
  assign imem_addr  = pc_reg;
  assign instret    = instret_reg;
  assign AdIn       = WAD'(instr_reg[11:7]);
  assign AdOut1     = WAD'(instr_reg[19:15]);
  assign AdOut2     = WAD'(instr_reg[24:20]);
  assign target     = pc_reg + IMM;
  // an ack only counts while a request is actually outstanding
  assign fetch_fire = imem_req && imem_ack;

  // State, PC, counter and instruction latch; run_reg keeps the request low until the first clock after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      run_reg     <= 1'b0;
      pc_reg      <= RESET_PC;
      instr_reg   <= WD'(NOP);
      instret_reg <= '0;
    end else begin
      state_reg   <= state_next;
      run_reg     <= 1'b1;
      pc_reg      <= pc_next;
      instret_reg <= instret_next;
      if (fetch_fire) begin
        instr_reg <= imem_rdata;
      end
    end
  end

  // Next-state, PC/counter update and FSM-driven outputs
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    instret_next = instret_reg;
    imem_req     = 1'b0;
    RegWrite     = 1'b0;
    halt         = 1'b0;
    case (state_reg)
      FETCH: begin
        imem_req = run_reg;
        if (run_reg && imem_ack) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        state_next = illegal ? HALT : EXEC;
      end
      EXEC: begin
        // rd = x0 is architecturally a no-op write
        RegWrite = wr_en && (instr_reg[11:7] != 5'd0);
        if (is_branch && !EQ) begin
          if (target[1:0] != 2'b00) begin
            state_next = HALT;
          end else begin
            pc_next      = target;
            instret_next = instret_reg + 1'b1;
            state_next   = FETCH;
          end
        end else begin
          pc_next      = pc_reg + WD'(4);
          instret_next = instret_reg + 1'b1;
          state_next   = FETCH;
        end
      end
      HALT: begin
        halt = 1'b1;
      end
      default: begin
        state_next = HALT;
      end
    endcase
  end

endmodule
